led_sequencer: RTL

Arbitrated blink-pattern controller that shares the board's single status LED between `NUM_REQ` requesters. Each requester presents an on/off/repeat pattern and holds a level request. The block grants the LED round-robin and times the pattern from a divided tick, then signals completion. It sits between client logic (status, error, heartbeat sources) and the `led` pad.

---
 rtl/led_ctrl_pkg.sv | 16 +
 rtl/led_sequencer_tick_prescaler.sv | 33 +++
 rtl/led_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the status-LED sequencer: FSM states and default
// pattern field widths.
package led_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ON     = 3'd2,
    S_OFF    = 3'd3,
    S_FINISH = 3'd4
  } led_state_e;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_RPT_W = 4;

endpackage

// File: rtl/led_sequencer_tick_prescaler.sv
// Divides the clock into a one-cycle tick every TICK_DIV cycles; clear
// restarts the division so the next tick is a full period away.
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Free-running divider; tick is registered one cycle ahead of the wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (clear) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= (cnt_r == CW'(TICK_DIV - 1)) ? '0 : cnt_r + CW'(1);
      tick_r <= (cnt_r == CW'(TICK_DIV - 2));
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/led_sequencer.sv
// Round-robin arbiter and blink-pattern timer sharing one status LED
// between NUM_REQ requesters.
module led_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = 50000,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int RPT_W    = DEF_RPT_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] on_ticks,
  input  logic [NUM_REQ*CNT_W-1:0] off_ticks,
  input  logic [NUM_REQ*RPT_W-1:0] repeats,
  output logic                     led,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  led_state_e         state_r;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   owner_r;
  logic [CNT_W-1:0]   on_r;
  logic [CNT_W-1:0]   off_r;
  logic [RPT_W-1:0]   rpt_left_r;
  logic [CNT_W-1:0]   ph_cnt_r;
  logic               led_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [NUM_REQ-1:0] done_r;
  logic               busy_r;

  logic               any_req_s;
  logic [IDX_W-1:0]   sel_s;
  logic [IDX_W-1:0]   nxt_ptr_s;
  logic [CNT_W-1:0]   on_in_s;
  logic [CNT_W-1:0]   off_in_s;
  logic [RPT_W-1:0]   rpt_in_s;
  logic [CNT_W-1:0]   on_tgt_s;
  logic               abort_s;
  logic               phase_done_s;
  logic               clear_s;
  logic               tick_s;

  // First pending request at or above the pointer, wrapping around.
  always_comb begin
    int idx;
    any_req_s = 1'b0;
    sel_s     = ptr_r;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_r) + i) % NUM_REQ;
      if (!any_req_s && req[idx]) begin
        any_req_s = 1'b1;
        sel_s     = IDX_W'(idx);
      end else begin
        any_req_s = any_req_s;
      end
    end
  end

  assign nxt_ptr_s = (owner_r == IDX_W'(NUM_REQ - 1)) ? '0 : owner_r + IDX_W'(1);
  assign on_in_s   = on_ticks[int'(owner_r)*CNT_W +: CNT_W];
  assign off_in_s  = off_ticks[int'(owner_r)*CNT_W +: CNT_W];
  assign rpt_in_s  = repeats[int'(owner_r)*RPT_W +: RPT_W];
  assign on_tgt_s  = (on_r == '0) ? CNT_W'(1) : on_r;
  assign abort_s   = ((state_r == S_LOAD) || (state_r == S_ON) || (state_r == S_OFF))
                     && !req[owner_r];

  // Phase end: last tick of ON, or last tick of OFF (a zero-length OFF ends at once).
  always_comb begin
    phase_done_s = 1'b0;
    case (state_r)
      S_ON:    phase_done_s = tick_s && (ph_cnt_r == on_tgt_s - CNT_W'(1));
      S_OFF:   phase_done_s = (off_r == '0) || (tick_s && (ph_cnt_r == off_r - CNT_W'(1)));
      default: phase_done_s = 1'b0;
    endcase
  end

  assign clear_s = !((state_r == S_ON) || (state_r == S_OFF)) || phase_done_s;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (clear_s),
    .tick   (tick_s)
  );

  // Sequencer FSM with registered LED, grant, done and busy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      ptr_r      <= '0;
      owner_r    <= '0;
      on_r       <= '0;
      off_r      <= '0;
      rpt_left_r <= '0;
      ph_cnt_r   <= '0;
      led_r      <= 1'b0;
      grant_r    <= '0;
      done_r     <= '0;
      busy_r     <= 1'b0;
    end else begin
      done_r <= '0;
      case (state_r)
        S_IDLE: begin
          if (any_req_s) begin
            owner_r <= sel_s;
            grant_r <= NUM_REQ'(1) << sel_s;
            busy_r  <= 1'b1;
            state_r <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort_s) begin
            grant_r <= '0;
            busy_r  <= 1'b0;
            ptr_r   <= nxt_ptr_s;
            state_r <= S_IDLE;
          end else begin
            on_r       <= on_in_s;
            off_r      <= off_in_s;
            rpt_left_r <= rpt_in_s;
            ph_cnt_r   <= '0;
            if (rpt_in_s == '0) begin
              done_r  <= grant_r;
              state_r <= S_FINISH;
            end else begin
              led_r   <= 1'b1;
              state_r <= S_ON;
            end
          end
        end
        S_ON: begin
          if (abort_s) begin
            led_r   <= 1'b0;
            grant_r <= '0;
            busy_r  <= 1'b0;
            ptr_r   <= nxt_ptr_s;
            state_r <= S_IDLE;
          end else if (phase_done_s) begin
            led_r    <= 1'b0;
            ph_cnt_r <= '0;
            state_r  <= S_OFF;
          end else if (tick_s) begin
            ph_cnt_r <= ph_cnt_r + CNT_W'(1);
          end
        end
        S_OFF: begin
          if (abort_s) begin
            led_r   <= 1'b0;
            grant_r <= '0;
            busy_r  <= 1'b0;
            ptr_r   <= nxt_ptr_s;
            state_r <= S_IDLE;
          end else if (phase_done_s) begin
            ph_cnt_r <= '0;
            if (rpt_left_r == RPT_W'(1)) begin
              done_r  <= grant_r;
              state_r <= S_FINISH;
            end else begin
              rpt_left_r <= rpt_left_r - RPT_W'(1);
              led_r      <= 1'b1;
              state_r    <= S_ON;
            end
          end else if (tick_s) begin
            ph_cnt_r <= ph_cnt_r + CNT_W'(1);
          end
        end
        S_FINISH: begin
          grant_r <= '0;
          busy_r  <= 1'b0;
          ptr_r   <= nxt_ptr_s;
          state_r <= S_IDLE;
        end
        default: begin
          led_r   <= 1'b0;
          grant_r <= '0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign led   = led_r;
  assign grant = grant_r;
  assign done  = done_r;
  assign busy  = busy_r;

endmodule
